// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch PC sequencer.
// Holds the sequencer state encoding and the alignment helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2,
    FAULT      = 2'd3
  } pc_seq_state_e;

  localparam logic [31:0] INSTR_BYTES = 32'd4;
  localparam logic [31:0] ALIGN_MASK  = 32'h0000_0003;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return ((addr & ALIGN_MASK) != 32'd0);
  endfunction

endpackage

// File: rtl/event_counter.sv
// Free-running wrap-around event counter with a count enable.
// The count is held in a register and driven straight to the output.
module event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_r;

  // Count register: increments on enable, wraps at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + CNT_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: issues sequential fetch requests, applies execute-stage
// redirects (static not-taken prediction) and pulses the pipeline flushes.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             fetch_req_valid,
  input  logic             fetch_req_ready,
  output logic [31:0]      fetch_addr,
  input  logic             stall,
  input  logic             br_valid,
  input  logic [31:0]      br_pc,
  input  logic [31:0]      br_pc_next,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  pc_seq_state_e state_r, state_s;
  logic [31:0]   addr_r, addr_s;
  logic [31:0]   target_r, target_s;
  logic [31:0]   hold_tgt_s;
  logic          valid_r, valid_s;
  logic          flush_if_r, flush_if_s;
  logic          flush_ex_r, flush_ex_s;
  logic          misalign_r, misalign_s;
  logic          fault_pend_r, fault_pend_s;
  logic          br_en_s, mis_en_s;
  logic          redirect_s, bad_tgt_s;
  logic          hs_s, held_s;

  assign redirect_s = br_valid && (br_pc_next != (br_pc + INSTR_BYTES));
  assign bad_tgt_s  = is_misaligned(br_pc_next);
  assign hs_s       = valid_r && fetch_req_ready;
  assign held_s     = valid_r && !fetch_req_ready;

  // Next-state, next-address, request valid and flush decode.
  always_comb begin
    state_s      = state_r;
    addr_s       = addr_r;
    target_s     = target_r;
    valid_s      = valid_r;
    flush_if_s   = 1'b0;
    flush_ex_s   = 1'b0;
    misalign_s   = misalign_r;
    fault_pend_s = fault_pend_r;
    br_en_s      = 1'b0;
    mis_en_s     = 1'b0;
    hold_tgt_s   = target_r;

    case (state_r)
      BOOT: begin
        state_s = RUN;
        valid_s = !stall;
      end

      RUN: begin
        br_en_s  = br_valid;
        mis_en_s = redirect_s;
        if (redirect_s && bad_tgt_s) begin
          flush_if_s = 1'b1;
          flush_ex_s = 1'b1;
          misalign_s = 1'b1;
          // A request already on the bus is allowed to finish before faulting.
          if (held_s) begin
            fault_pend_s = 1'b1;
            valid_s      = 1'b1;
            state_s      = HOLD_REDIR;
          end else begin
            valid_s = 1'b0;
            state_s = FAULT;
          end
        end else if (redirect_s) begin
          flush_if_s = 1'b1;
          flush_ex_s = 1'b1;
          if (held_s) begin
            target_s = br_pc_next;
            valid_s  = 1'b1;
            state_s  = HOLD_REDIR;
          end else begin
            addr_s  = br_pc_next;
            valid_s = !stall;
          end
        end else begin
          if (hs_s) begin
            addr_s = addr_r + INSTR_BYTES;
          end else begin
            addr_s = addr_r;
          end
          valid_s = held_s || !stall;
        end
      end

      HOLD_REDIR: begin
        if (fault_pend_r) begin
          if (hs_s) begin
            fault_pend_s = 1'b0;
            valid_s      = 1'b0;
            state_s      = FAULT;
          end else begin
            valid_s = 1'b1;
          end
        end else begin
          br_en_s  = br_valid;
          mis_en_s = redirect_s;
          if (redirect_s && bad_tgt_s) begin
            flush_if_s = 1'b1;
            flush_ex_s = 1'b1;
            misalign_s = 1'b1;
            if (held_s) begin
              fault_pend_s = 1'b1;
              valid_s      = 1'b1;
            end else begin
              valid_s = 1'b0;
              state_s = FAULT;
            end
          end else begin
            // Newest redirect replaces the latched target.
            if (redirect_s) begin
              hold_tgt_s = br_pc_next;
              flush_if_s = 1'b1;
              flush_ex_s = 1'b1;
            end else begin
              hold_tgt_s = target_r;
            end
            if (hs_s) begin
              addr_s     = hold_tgt_s;
              flush_if_s = 1'b1;
              valid_s    = !stall;
              state_s    = RUN;
            end else begin
              target_s = hold_tgt_s;
              valid_s  = 1'b1;
            end
          end
        end
      end

      FAULT: begin
        valid_s = 1'b0;
      end

      default: begin
        valid_s = 1'b0;
        state_s = FAULT;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= BOOT;
      addr_r       <= RESET_PC;
      target_r     <= 32'd0;
      valid_r      <= 1'b0;
      flush_if_r   <= 1'b0;
      flush_ex_r   <= 1'b0;
      misalign_r   <= 1'b0;
      fault_pend_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      addr_r       <= addr_s;
      target_r     <= target_s;
      valid_r      <= valid_s;
      flush_if_r   <= flush_if_s;
      flush_ex_r   <= flush_ex_s;
      misalign_r   <= misalign_s;
      fault_pend_r <= fault_pend_s;
    end
  end

  event_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (br_en_s),
    .count (br_count)
  );

  event_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mis_en_s),
    .count (mispred_count)
  );

  assign fetch_req_valid = valid_r;
  assign fetch_addr      = addr_r;
  assign flush_if_id     = flush_if_r;
  assign flush_id_ex     = flush_ex_r;
  assign misalign_err    = misalign_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a fetch-stream
// reference model (expected accepted addresses, flush pulses and counts).
module tb_pc_sequencer;

  logic        clk;
  logic        rst_n;
  logic        fetch_req_valid;
  logic        fetch_req_ready;
  logic [31:0] fetch_addr;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_pc;
  logic [31:0] br_pc_next;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        misalign_err;
  logic [15:0] br_count;
  logic [15:0] mispred_count;

  int tests;
  int fails;

  // Reference model state for the randomized phase
  logic [31:0] m_fetch;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        m_valid;
  logic        m_fi;
  logic        m_fx;
  logic [15:0] m_brc;
  logic [15:0] m_misc;

  pc_sequencer #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .fetch_req_valid (fetch_req_valid),
    .fetch_req_ready (fetch_req_ready),
    .fetch_addr      (fetch_addr),
    .stall           (stall),
    .br_valid        (br_valid),
    .br_pc           (br_pc),
    .br_pc_next      (br_pc_next),
    .flush_if_id     (flush_if_id),
    .flush_id_ex     (flush_id_ex),
    .misalign_err    (misalign_err),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"},  {31'd0, fetch_req_valid}, 32'd0);
    chk({tag, "_addr"},   fetch_addr, 32'h0000_0000);
    chk({tag, "_fif"},    {31'd0, flush_if_id}, 32'd0);
    chk({tag, "_fex"},    {31'd0, flush_id_ex}, 32'd0);
    chk({tag, "_mis"},    {31'd0, misalign_err}, 32'd0);
    chk({tag, "_brc"},    {16'd0, br_count}, 32'd0);
    chk({tag, "_mpc"},    {16'd0, mispred_count}, 32'd0);
  endtask

  // Reset pulse leaving the DUT in its first RUN cycle with ready=1, stall=0
  task automatic reset_and_start();
    br_valid        = 1'b0;
    fetch_req_ready = 1'b1;
    stall           = 1'b0;
    rst_n           = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One randomized cycle: check this cycle, drive random inputs, advance model
  task automatic rand_cycle();
    logic        red;
    logic        hs;
    logic        held;
    logic [31:0] pc;
    logic [31:0] tg;
    chk("rnd_valid", {31'd0, fetch_req_valid}, {31'd0, m_valid});
    chk("rnd_fif",   {31'd0, flush_if_id},     {31'd0, m_fi});
    chk("rnd_fex",   {31'd0, flush_id_ex},     {31'd0, m_fx});
    chk("rnd_brc",   {16'd0, br_count},        {16'd0, m_brc});
    chk("rnd_mpc",   {16'd0, mispred_count},   {16'd0, m_misc});

    fetch_req_ready = ($urandom_range(0, 9) < 7);
    stall           = ($urandom_range(0, 9) < 3);
    br_valid        = ($urandom_range(0, 9) < 3);
    pc              = $urandom;
    pc[1:0]         = 2'b00;
    tg              = $urandom;
    tg[1:0]         = 2'b00;
    br_pc           = pc;
    br_pc_next      = ($urandom_range(0, 1) == 0) ? pc + 32'd4 : tg;

    hs   = m_valid && fetch_req_ready;
    held = m_valid && !fetch_req_ready;
    red  = br_valid && (br_pc_next != br_pc + 32'd4);
    m_fi = 1'b0;
    if (hs) begin
      chk("rnd_accept_addr", fetch_addr, m_fetch);
      m_fi    = m_pend;
      m_fetch = m_pend ? m_tgt : m_fetch + 32'd4;
      m_pend  = 1'b0;
    end
    if (red) begin
      if (held) begin
        m_pend = 1'b1;
        m_tgt  = br_pc_next;
      end else begin
        m_fetch = br_pc_next;
        m_pend  = 1'b0;
      end
      m_misc = m_misc + 16'd1;
    end
    if (br_valid) m_brc = m_brc + 16'd1;
    m_fi    = m_fi || red;
    m_fx    = red;
    m_valid = held || !stall;
    tick();
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    rst_n           = 1'b0;
    fetch_req_ready = 1'b0;
    stall           = 1'b0;
    br_valid        = 1'b0;
    br_pc           = 32'd0;
    br_pc_next      = 32'd0;
    tick();
    tick();
    chk_reset_vals("reset");

    // Reset release: BOOT for one cycle, then sequential fetch from 0x0
    fetch_req_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("boot_valid", {31'd0, fetch_req_valid}, 32'd1);
    chk("seq_addr0",  fetch_addr, 32'h0);
    tick();
    chk("seq_addr1",  fetch_addr, 32'h4);
    tick();
    chk("seq_addr2",  fetch_addr, 32'h8);
    chk("seq_noflush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);

    // Not-taken branch: counted, no flush
    br_valid = 1'b1; br_pc = 32'h10; br_pc_next = 32'h14;
    tick();
    chk("nt_fex",  {31'd0, flush_id_ex}, 32'd0);
    chk("nt_brc",  {16'd0, br_count}, 32'd1);
    chk("nt_mpc",  {16'd0, mispred_count}, 32'd0);
    chk("nt_addr", fetch_addr, 32'hC);

    // Taken redirect with the handshake completing the same cycle
    br_pc_next = 32'h40;
    tick();
    br_valid = 1'b0;
    chk("red_addr",  fetch_addr, 32'h40);
    chk("red_fif",   {31'd0, flush_if_id}, 32'd1);
    chk("red_fex",   {31'd0, flush_id_ex}, 32'd1);
    chk("red_valid", {31'd0, fetch_req_valid}, 32'd1);
    chk("red_mpc",   {16'd0, mispred_count}, 32'd1);
    tick();
    chk("red_next",  fetch_addr, 32'h44);
    chk("red_pulse", {30'd0, flush_if_id, flush_id_ex}, 32'd0);

    // Randomized traffic against the reference model
    m_fetch = 32'h44; m_pend = 1'b0; m_tgt = 32'd0;
    m_valid = 1'b1; m_fi = 1'b0; m_fx = 1'b0;
    m_brc = 16'd2; m_misc = 16'd1;
    for (int i = 0; i < 400; i++) rand_cycle();
    br_valid = 1'b0;

    // Redirect while 0x20 is held by a stalled fetch port
    reset_and_start();
    repeat (8) tick();
    chk("hold_addr", fetch_addr, 32'h20);
    fetch_req_ready = 1'b0;
    tick();
    br_valid = 1'b1; br_pc = 32'h30; br_pc_next = 32'h80;
    tick();
    br_valid = 1'b0;
    chk("hold_keep0", fetch_addr, 32'h20);
    chk("hold_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    chk("hold_valid", {31'd0, fetch_req_valid}, 32'd1);
    tick();
    chk("hold_keep1", fetch_addr, 32'h20);
    chk("hold_pulse", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    fetch_req_ready = 1'b1;
    tick();
    chk("hold_tgt",   fetch_addr, 32'h80);
    chk("hold_fif2",  {30'd0, flush_if_id, flush_id_ex}, 32'd2);
    tick();
    chk("hold_tgt4",  fetch_addr, 32'h84);

    // Misaligned redirect: sticky error, fetch stops, later branches ignored
    reset_and_start();
    repeat (2) tick();
    br_valid = 1'b1; br_pc = 32'h8; br_pc_next = 32'h42;
    tick();
    chk("mis_err",   {31'd0, misalign_err}, 32'd1);
    chk("mis_valid", {31'd0, fetch_req_valid}, 32'd0);
    chk("mis_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd3);
    chk("mis_mpc",   {16'd0, mispred_count}, 32'd1);
    br_pc = 32'h100; br_pc_next = 32'h200;
    repeat (3) tick();
    br_valid = 1'b0;
    chk("fault_valid", {31'd0, fetch_req_valid}, 32'd0);
    chk("fault_brc",   {16'd0, br_count}, 32'd1);
    chk("fault_mpc",   {16'd0, mispred_count}, 32'd1);
    chk("fault_flush", {30'd0, flush_if_id, flush_id_ex}, 32'd0);
    chk("fault_err",   {31'd0, misalign_err}, 32'd1);
    reset_and_start();
    chk("fault_rst_addr",  fetch_addr, 32'h0);
    chk("fault_rst_valid", {31'd0, fetch_req_valid}, 32'd1);
    chk("fault_rst_err",   {31'd0, misalign_err}, 32'd0);

    // Asynchronous reset while a redirect target is latched
    repeat (3) tick();
    fetch_req_ready = 1'b0;
    br_valid = 1'b1; br_pc = 32'h50; br_pc_next = 32'h200;
    tick();
    br_valid = 1'b0;
    chk("arst_hold_fex", {31'd0, flush_id_ex}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst");
    tick();
    fetch_req_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("arst_addr0", fetch_addr, 32'h0);
    tick();
    chk("arst_addr1", fetch_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Owns the architectural fetch PC and sequences redirects coming from the execute-stage branch unit. It issues fetch addresses over a valid/ready request channel and predicts not-taken statically. When execute reports a resolved control-flow instruction whose next PC differs from `pc+4`, it loads the target and pulses flush signals to squash the wrong-path IF/ID and ID/EX contents. It sits between the branch unit's `pc_next` output and the instruction-fetch port.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `CNT_W`, 16, width of the branch and mispredict event counters
- `clk`  in  1  core clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `fetch_req_valid`  out  1  fetch request valid
- `fetch_req_ready`  in  1  fetch port accepts the request this cycle
- `fetch_addr`  out  32  fetch address; stable while `valid && !ready`
- `stall`  in  1  hazard stall; suppresses new requests only
- `br_valid`  in  1  execute holds a resolved jal/jalr/branch this cycle
- `br_pc`  in  32  PC of that instruction
- `br_pc_next`  in  32  resolved next PC from the branch unit
- `flush_if_id`  out  1  squash IF/ID register
- `flush_id_ex`  out  1  squash ID/EX register
- `misalign_err`  out  1  sticky; redirect target not word aligned
- `br_count`  out  CNT_W  resolved control instructions, wraps
- `mispred_count`  out  CNT_W  redirects taken, wraps

## Operation
- States: BOOT, RUN, HOLD_REDIR, FAULT.
- A redirect is `br_valid && br_pc_next != br_pc + 32'd4`. The add wraps modulo 2^32.
- A redirect is misaligned when `br_pc_next[1:0] != 0`.
- BOOT:
  - Present for one cycle after `rst_n` deasserts.
  - Always goes to RUN. `br_valid` is ignored in BOOT.
- RUN:
  - `fetch_req_valid = !stall`, except that a request already shown and not yet accepted stays valid.
  - On handshake, `fetch_addr += 4` next cycle.
- Redirect in RUN with no pending request, or with the handshake completing in the same cycle:
  - `fetch_addr <= br_pc_next`.
  - Both flushes pulse for one cycle.
  - State stays RUN.
- Redirect while a request is held (`valid && !ready`):
  - Address is held and the target is latched; go to HOLD_REDIR.
  - Both flushes pulse in the next cycle.
- HOLD_REDIR:
  - `fetch_req_valid = 1`.
  - On acceptance, `fetch_addr <= latched target` and `flush_if_id` pulses again to squash the wrong-path fetch; return to RUN.
  - A new redirect in HOLD_REDIR overwrites the latched target; the newest wins.
- Misaligned redirect in RUN or HOLD_REDIR:
  - Both flushes pulse and `misalign_err <= 1`; go to FAULT.
  - `fetch_req_valid` drops immediately unless a request is held; a held request is allowed to complete first.
  - In FAULT, `fetch_req_valid = 0` and all inputs are ignored. Only reset exits FAULT.
- Counters:
  - `br_count` increments on every `br_valid` outside BOOT and FAULT.
  - `mispred_count` increments on every redirect, including a misaligned one.
- `stall` concurrent with a redirect: the redirect is still applied, and valid follows `stall`.

## Timing
- Reset values:
  - `fetch_addr = RESET_PC`.
  - `fetch_req_valid`, both flushes, `misalign_err` = 0.
  - Both counters = 0.
  - State = BOOT.
- First `fetch_req_valid = 1` occurs in the second cycle after reset release, if `stall = 0`.
- Redirect latency: `br_valid` at cycle N → flushes and new `fetch_addr` registered, visible at N+1.
- The earliest fetch of the target is accepted at N+1.
- Flushes are registered and last exactly one cycle per event.
- Reset asserted mid-operation clears everything asynchronously, including pending targets.

## Structure
- `pc_seq_pkg` holds:
  - the `pc_seq_state_e` enum (BOOT, RUN, HOLD_REDIR, FAULT);
  - `INSTR_BYTES = 4`;
  - the `ALIGN_MASK` constant.
- One sub-module: `event_counter` (CNT_W wrap counter with an enable), instantiated twice.
- The redirect comparator stays inline.

## Test plan
- Reset release, `ready = 1`, `stall = 0`: addresses 0x0, 0x4, 0x8 on consecutive cycles from cycle 2; no flushes.
- `br_valid`, `br_pc = 0x10`, `br_pc_next = 0x14` (not taken): no flush; `br_count = 1`, `mispred_count = 0`.
- `br_valid`, `br_pc = 0x10`, `br_pc_next = 0x40`, `ready = 1`: next cycle `fetch_addr = 0x40` with a single-cycle flush pulse; then 0x44.
- `ready = 0` holding 0x20 when a redirect to 0x80 arrives:
  - 0x20 stays on `fetch_addr` until `ready` rises.
  - Flushes pulse at N+1, and `flush_if_id` pulses again after acceptance.
  - The next address is 0x80.
- Redirect to 0x42: `misalign_err = 1`, `valid = 0` thereafter; later `br_valid` is ignored; after a reset pulse, fetch restarts at `RESET_PC`.
- Assert `rst_n` low while in HOLD_REDIR: outputs go to reset values immediately; after release, fetch starts from `RESET_PC`, not the latched target.
